pipe_stage_elastic: RTL and testbench

- Parametrised elastic pipeline-stage register that replaces the fixed inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) of the RISC-V merge-sort core.
- Carries a data bundle and a control bundle with a valid/ready handshake, a 2-entry skid buffer, synchronous flush, and NOP-squashing of control when the stage is empty.
- Hazard and branch logic drives out_ready (stall) and flush (kill) directly.

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/pipe_sat_cnt.sv | 32 +++
 rtl/pipe_stage_elastic.sv | 131 +++++++++++++
 tb/tb_pipe_stage_elastic.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage registers of the merge-sort core.
package pipe_pkg;

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StTwo   = 2'd2
   } stage_state_e;

   // IF/ID: pc, pc+4, instruction
   localparam int unsigned IFID_DATA_W  = 96;
   localparam int unsigned IFID_CTRL_W  = 4;
   localparam logic [IFID_CTRL_W-1:0] IFID_CTRL_NOP = '0;

   // ID/EX: rs1, rs2, imm, pc, pc+4
   localparam int unsigned IDEX_DATA_W  = 160;
   localparam int unsigned IDEX_CTRL_W  = 20;
   localparam logic [IDEX_CTRL_W-1:0] IDEX_CTRL_NOP = '0;

   // EX/MEM: alu result, store data, pc+4
   localparam int unsigned EXMEM_DATA_W = 96;
   localparam int unsigned EXMEM_CTRL_W = 12;
   localparam logic [EXMEM_CTRL_W-1:0] EXMEM_CTRL_NOP = '0;

   // MEM/WB: alu result, load data, pc+4
   localparam int unsigned MEMWB_DATA_W = 96;
   localparam int unsigned MEMWB_CTRL_W = 8;
   localparam logic [MEMWB_CTRL_W-1:0] MEMWB_CTRL_NOP = '0;

endpackage

// File: rtl/pipe_sat_cnt.sv
// 32-bit saturating event counter with enable and a synchronous load.
module pipe_sat_cnt (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        load,
   input  logic [31:0] load_val,
   output logic [31:0] cnt
);

   logic [31:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != 32'hFFFF_FFFF)) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: valid/ready handshake, 2-entry skid, flush, NOP-squashed control.
// Define PIPE_STAGE_PERF_EN to add saturating stall/bubble counters.
module pipe_stage_elastic
   import pipe_pkg::*;
#(
   parameter int unsigned       DATA_W   = 160,
   parameter int unsigned       CTRL_W   = 20,
   parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       bubble_cnt
`endif
);

   stage_state_e      state_q, state_d;
   logic              in_ready_q;
   logic [DATA_W-1:0] main_data_q, skid_data_q;
   logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
   logic              push, pop;
   logic              load_main_in, load_main_skid, load_skid;

   assign out_valid = (state_q != StEmpty);
   assign push      = in_valid & in_ready_q;
   assign pop       = out_valid & out_ready;

   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      // Flush wins over everything, including a same-cycle push.
      if (flush) begin
         state_d = StEmpty;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (push) begin
                  state_d      = StOne;
                  load_main_in = 1'b1;
               end
            end
            StOne: begin
               if (push && !pop) begin
                  state_d   = StTwo;
                  load_skid = 1'b1;
               end else if (push && pop) begin
                  load_main_in = 1'b1;
               end else if (pop) begin
                  state_d = StEmpty;
               end
            end
            StTwo: begin
               if (pop) begin
                  state_d        = StOne;
                  load_main_skid = 1'b1;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StEmpty;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != StTwo);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_data_q <= '0;
         main_ctrl_q <= CTRL_NOP;
         skid_data_q <= '0;
         skid_ctrl_q <= CTRL_NOP;
      end else begin
         if (load_main_in) begin
            main_data_q <= in_data;
            main_ctrl_q <= in_ctrl;
         end else if (load_main_skid) begin
            main_data_q <= skid_data_q;
            main_ctrl_q <= skid_ctrl_q;
         end
         if (load_skid) begin
            skid_data_q <= in_data;
            skid_ctrl_q <= in_ctrl;
         end
      end
   end

   assign in_ready = in_ready_q;
   assign out_data = main_data_q;
   assign out_ctrl = out_valid ? main_ctrl_q : CTRL_NOP;

`ifdef PIPE_STAGE_PERF_EN
   pipe_sat_cnt u_stall_cnt (
      .clk      (clk),
      .reset    (reset),
      .en       (out_valid & ~out_ready),
      .load     (1'b0),
      .load_val (32'd0),
      .cnt      (stall_cnt)
   );

   pipe_sat_cnt u_bubble_cnt (
      .clk      (clk),
      .reset    (reset),
      .en       (~out_valid),
      .load     (1'b0),
      .load_val (32'd0),
      .cnt      (bubble_cnt)
   );
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic: directed table, corner sequences, random vs queue model.
module tb_pipe_stage_elastic;

   localparam int unsigned DW  = 16;
   localparam int unsigned CW  = 8;
   localparam logic [CW-1:0] NOP = 8'h5A;

   logic          clk = 1'b0;
   logic          reset;
   logic          flush, in_valid, in_ready, out_valid, out_ready;
   logic [DW-1:0] in_data, out_data;
   logic [CW-1:0] in_ctrl, out_ctrl;
`ifdef PIPE_STAGE_PERF_EN
   logic [31:0]   stall_cnt, bubble_cnt;
`endif
   logic          cnt_en, cnt_load;
   logic [31:0]   cnt_val, cnt_out;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pipe_stage_elastic #(
      .DATA_W   (DW),
      .CTRL_W   (CW),
      .CTRL_NOP (NOP)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt)
`endif
   );

   pipe_sat_cnt u_cnt (
      .clk      (clk),
      .reset    (reset),
      .en       (cnt_en),
      .load     (cnt_load),
      .load_val (cnt_val),
      .cnt      (cnt_out)
   );

   typedef struct {
      logic          fl;
      logic          iv;
      logic [DW-1:0] d;
      logic [CW-1:0] c;
      logic          ordy;
      logic          ev;
      logic          er;
      logic [DW-1:0] ed;
      logic [CW-1:0] ec;
   } vec_t;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [CW-1:0] c;
   } ent_t;

   vec_t tbl[15];
   ent_t q[$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic fl, input logic iv, input logic [DW-1:0] d,
                        input logic [CW-1:0] c, input logic ordy);
      flush     = fl;
      in_valid  = iv;
      in_data   = d;
      in_ctrl   = c;
      out_ready = ordy;
   endtask

   initial begin
      logic          ir_m, push_m, pop_m, fl_r;
      logic [DW-1:0] last_m;
      int unsigned   stall_m, bub_m;

      reset = 1'b1;
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      cnt_en = 1'b0; cnt_load = 1'b0; cnt_val = '0;
      step(); step();
      reset = 1'b0;

      chk("reset out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset in_ready", {31'd0, in_ready}, 32'd1);
      chk("reset out_ctrl", {24'd0, out_ctrl}, {24'd0, NOP});
      chk("reset out_data", {16'd0, out_data}, 32'd0);
      chk("reset cnt", cnt_out, 32'd0);

      // Directed table: inputs applied for one edge, outputs expected afterwards.
      tbl[0]  = '{1'b0, 1'b1, 16'h00A5, 8'h01, 1'b1, 1'b1, 1'b1, 16'h00A5, 8'h01};
      tbl[1]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 16'h00A5, NOP};
      tbl[2]  = '{1'b0, 1'b1, 16'h0011, 8'h11, 1'b0, 1'b1, 1'b1, 16'h0011, 8'h11};
      tbl[3]  = '{1'b0, 1'b1, 16'h0022, 8'h22, 1'b0, 1'b1, 1'b0, 16'h0011, 8'h11};
      tbl[4]  = '{1'b0, 1'b1, 16'h0033, 8'h33, 1'b0, 1'b1, 1'b0, 16'h0011, 8'h11};
      tbl[5]  = '{1'b0, 1'b1, 16'h0033, 8'h33, 1'b1, 1'b1, 1'b1, 16'h0022, 8'h22};
      tbl[6]  = '{1'b0, 1'b1, 16'h0033, 8'h33, 1'b1, 1'b1, 1'b1, 16'h0033, 8'h33};
      tbl[7]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 16'h0033, NOP};
      tbl[8]  = '{1'b0, 1'b1, 16'h0044, 8'h44, 1'b0, 1'b1, 1'b1, 16'h0044, 8'h44};
      tbl[9]  = '{1'b0, 1'b1, 16'h0055, 8'h55, 1'b0, 1'b1, 1'b0, 16'h0044, 8'h44};
      tbl[10] = '{1'b1, 1'b1, 16'h0066, 8'h66, 1'b0, 1'b0, 1'b1, 16'h0044, NOP};
      tbl[11] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 16'h0044, NOP};
      tbl[12] = '{1'b1, 1'b1, 16'h0077, 8'h77, 1'b1, 1'b0, 1'b1, 16'h0044, NOP};
      tbl[13] = '{1'b0, 1'b1, 16'h0088, 8'h88, 1'b1, 1'b1, 1'b1, 16'h0088, 8'h88};
      tbl[14] = '{1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 16'h0088, NOP};

      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].c, tbl[i].ordy);
         step();
         chk($sformatf("tbl[%0d] out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ev});
         chk($sformatf("tbl[%0d] in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].er});
         chk($sformatf("tbl[%0d] out_data", i), {16'd0, out_data}, {16'd0, tbl[i].ed});
         chk($sformatf("tbl[%0d] out_ctrl", i), {24'd0, out_ctrl}, {24'd0, tbl[i].ec});
      end

      // Streaming: one entry per cycle, no bubbles.
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b1, 16'(16'h0100 + i), 8'(i), 1'b1);
         step();
         chk($sformatf("stream[%0d] out_valid", i), {31'd0, out_valid}, 32'd1);
         chk($sformatf("stream[%0d] out_data", i), {16'd0, out_data}, 32'h100 + i);
         chk($sformatf("stream[%0d] in_ready", i), {31'd0, in_ready}, 32'd1);
      end
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      step();
      chk("stream drain out_valid", {31'd0, out_valid}, 32'd0);

      // Asynchronous reset while stalled with two entries.
      drive(1'b0, 1'b1, 16'h00C1, 8'hC1, 1'b0);
      step();
      drive(1'b0, 1'b1, 16'h00C2, 8'hC2, 1'b0);
      step();
      chk("pre-reset in_ready", {31'd0, in_ready}, 32'd0);
      #2 reset = 1'b1;
      #1;
      chk("async reset out_valid", {31'd0, out_valid}, 32'd0);
      chk("async reset out_ctrl", {24'd0, out_ctrl}, {24'd0, NOP});
      chk("async reset out_data", {16'd0, out_data}, 32'd0);
      step();
      reset = 1'b0;
      chk("post-reset in_ready", {31'd0, in_ready}, 32'd1);
      drive(1'b0, 1'b1, 16'h0099, 8'h09, 1'b0);
      step();
      chk("first push after reset valid", {31'd0, out_valid}, 32'd1);
      chk("first push after reset data", {16'd0, out_data}, 32'h99);
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      for (int i = 0; i < 4; i++) step();
      chk("long stall data", {16'd0, out_data}, 32'h99);
      chk("long stall ctrl", {24'd0, out_ctrl}, 32'h09);

      // Saturating counter: count, preload near the top, then saturate.
      cnt_en = 1'b1;
      for (int i = 0; i < 3; i++) step();
      cnt_en = 1'b0;
      step();
      chk("cnt count 3", cnt_out, 32'd3);
      cnt_load = 1'b1; cnt_val = 32'hFFFF_FFFE;
      step();
      cnt_load = 1'b0;
      chk("cnt preload", cnt_out, 32'hFFFF_FFFE);
      cnt_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("cnt sat[%0d]", i), cnt_out, 32'hFFFF_FFFF);
      end
      cnt_en = 1'b0;

`ifdef PIPE_STAGE_PERF_EN
      reset = 1'b1;
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      step();
      reset = 1'b0;
      drive(1'b0, 1'b1, 16'h0042, 8'h42, 1'b0);
      step();
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      for (int i = 0; i < 5; i++) step();
      out_ready = 1'b1;
      step();
      for (int i = 0; i < 3; i++) step();
      chk("perf stall_cnt", stall_cnt, 32'd5);
      chk("perf bubble_cnt", bubble_cnt, 32'd4);
`endif

      // Random traffic against a queue-based model of the stage.
      reset = 1'b1;
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      step();
      reset = 1'b0;
      q.delete();
      ir_m = 1'b1; last_m = '0; stall_m = 0; bub_m = 0;
      for (int cyc = 0; cyc < 500; cyc++) begin
         fl_r = ($urandom_range(0, 15) == 0);
         drive(fl_r, ($urandom_range(0, 3) != 0), DW'($urandom), CW'($urandom),
               ($urandom_range(0, 2) != 0));
         push_m = in_valid && ir_m;
         pop_m  = (q.size() != 0) && out_ready;
         if (q.size() != 0 && !out_ready) stall_m++;
         if (q.size() == 0) bub_m++;
         step();
         if (fl_r) begin
            q.delete();
         end else begin
            if (pop_m) void'(q.pop_front());
            if (push_m) q.push_back('{d: in_data, c: in_ctrl});
         end
         ir_m = (q.size() < 2);
         if (q.size() != 0) last_m = q[0].d;
         chk("rnd out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
         chk("rnd in_ready", {31'd0, in_ready}, {31'd0, ir_m});
         chk("rnd out_data", {16'd0, out_data}, {16'd0, last_m});
         chk("rnd out_ctrl", {24'd0, out_ctrl},
             {24'd0, (q.size() != 0) ? q[0].c : NOP});
`ifdef PIPE_STAGE_PERF_EN
         chk("rnd stall_cnt", stall_cnt, stall_m);
         chk("rnd bubble_cnt", bubble_cnt, bub_m);
`endif
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
